// File: rtl/rtu_rsp_dispatcher.sv
// rtu_rsp_dispatcher
// Producer side of the swcore RTU response interface. Takes one stream of
// lookup results from the RTU match engine, each tagged with its source port,
// sanitises mask/drop, and keeps a two-deep FIFO per port. The head entry
// drives that port's valid/mask/drop/prio outputs until the swcore acks it.
module rtu_rsp_dispatcher #(
  parameter int g_num_ports      = 11,
  parameter int g_prio_width     = 3,
  parameter int g_port_idx_width = 4,
  parameter bit g_allow_loopback = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [g_port_idx_width-1:0]            req_port_i,
  input  logic [g_num_ports-1:0]                 req_mask_i,
  input  logic                                   req_drop_i,
  input  logic [g_prio_width-1:0]                req_prio_i,
  output logic [g_num_ports-1:0]                 rtu_rsp_valid_o,
  input  logic [g_num_ports-1:0]                 rtu_rsp_ack_i,
  output logic [g_num_ports*g_num_ports-1:0]     rtu_dst_port_mask_o,
  output logic [g_num_ports-1:0]                 rtu_drop_o,
  output logic [g_num_ports*g_prio_width-1:0]    rtu_prio_o,
  output logic                                   err_o
);

  localparam int N = g_num_ports;
  localparam int P = g_prio_width;

  // Per-port storage: head slot drives the outputs, tail slot queues behind it.
  // occ counts entries (0, 1 or 2); the empty head is held at zero so the
  // output slices read 0 whenever valid is low.
  logic [1:0]   occ    [N];
  logic [N-1:0] h_mask [N];
  logic         h_drop [N];
  logic [P-1:0] h_prio [N];
  logic [N-1:0] t_mask [N];
  logic         t_drop [N];
  logic [P-1:0] t_prio [N];

  logic [31:0]  port_ext;
  logic         port_oor;
  logic [N-1:0] sel_oh;
  logic [N-1:0] full_vec;
  logic [N-1:0] pop_vec;
  logic [N-1:0] push_vec;
  logic         accept;
  logic [N-1:0] san_mask;
  logic         san_drop;

  // Decode the request port into a one-hot select; out-of-range ports select nothing.
  always_comb begin
    port_ext = 32'(req_port_i);
    port_oor = (port_ext >= N);
    sel_oh   = '0;
    if (!port_oor)
      sel_oh = {{(N-1){1'b0}}, 1'b1} << req_port_i;
  end

  // Per-port full and pop flags; an ack on an empty port is ignored.
  always_comb begin
    full_vec = '0;
    pop_vec  = '0;
    for (int i = 0; i < N; i++) begin
      full_vec[i] = (occ[i] == 2'd2);
      pop_vec[i]  = rtu_rsp_ack_i[i] && (occ[i] != 2'd0);
    end
  end

  // A full port can still accept when it is being acked in the same cycle.
  always_comb begin
    req_ready_o = !rst_i && (port_oor || !(|(sel_oh & full_vec & ~rtu_rsp_ack_i)));
    accept      = req_valid_i && req_ready_o;
    push_vec    = accept ? sel_oh : '0;
  end

  // Sanitise: optionally strip the source port's own bit, and drop anything
  // that ends up with nowhere to go.
  always_comb begin
    san_mask = g_allow_loopback ? req_mask_i : (req_mask_i & ~sel_oh);
    san_drop = req_drop_i || (san_mask == '0);
  end

  // FIFO update per port: pop happens before push, so a simultaneous
  // ack and accept keeps occupancy and queues the new entry last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
      for (int i = 0; i < N; i++) begin
        occ[i]    <= 2'd0;
        h_mask[i] <= '0;
        h_drop[i] <= 1'b0;
        h_prio[i] <= '0;
        t_mask[i] <= '0;
        t_drop[i] <= 1'b0;
        t_prio[i] <= '0;
      end
    end else begin
      err_o <= accept && port_oor;
      for (int i = 0; i < N; i++) begin
        if (pop_vec[i]) begin
          if (occ[i] == 2'd2) begin
            h_mask[i] <= t_mask[i];
            h_drop[i] <= t_drop[i];
            h_prio[i] <= t_prio[i];
            if (push_vec[i]) begin
              t_mask[i] <= san_mask;
              t_drop[i] <= san_drop;
              t_prio[i] <= req_prio_i;
            end else begin
              t_mask[i] <= '0;
              t_drop[i] <= 1'b0;
              t_prio[i] <= '0;
              occ[i]    <= 2'd1;
            end
          end else begin
            if (push_vec[i]) begin
              h_mask[i] <= san_mask;
              h_drop[i] <= san_drop;
              h_prio[i] <= req_prio_i;
            end else begin
              h_mask[i] <= '0;
              h_drop[i] <= 1'b0;
              h_prio[i] <= '0;
              occ[i]    <= 2'd0;
            end
          end
        end else if (push_vec[i]) begin
          if (occ[i] == 2'd0) begin
            h_mask[i] <= san_mask;
            h_drop[i] <= san_drop;
            h_prio[i] <= req_prio_i;
            occ[i]    <= 2'd1;
          end else begin
            t_mask[i] <= san_mask;
            t_drop[i] <= san_drop;
            t_prio[i] <= req_prio_i;
            occ[i]    <= 2'd2;
          end
        end
      end
    end
  end

  // Flatten the head slots onto the per-port output slices.
  for (genvar gi = 0; gi < N; gi++) begin : g_out
    assign rtu_rsp_valid_o[gi]             = (occ[gi] != 2'd0);
    assign rtu_dst_port_mask_o[gi*N +: N]  = h_mask[gi];
    assign rtu_drop_o[gi]                  = h_drop[gi];
    assign rtu_prio_o[gi*P +: P]           = h_prio[gi];
  end

endmodule

// File: tb/tb_rtu_rsp_dispatcher.sv
// Testbench for rtu_rsp_dispatcher: a directed vector table, random traffic
// against a queue-based reference model, and a held-ack sequence.
module tb_rtu_rsp_dispatcher;

  localparam int N = 11;
  localparam int P = 3;
  localparam int W = 4;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_port;
  logic [N-1:0]     req_mask;
  logic             req_drop;
  logic [P-1:0]     req_prio;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ack;
  logic [N*N-1:0]   dst_mask;
  logic [N-1:0]     drop_o;
  logic [N*P-1:0]   prio_o;
  logic             err;

  int errors = 0;
  int checks = 0;

  rtu_rsp_dispatcher #(
    .g_num_ports(N), .g_prio_width(P), .g_port_idx_width(W), .g_allow_loopback(1'b0)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_port_i          (req_port),
    .req_mask_i          (req_mask),
    .req_drop_i          (req_drop),
    .req_prio_i          (req_prio),
    .rtu_rsp_valid_o     (rsp_valid),
    .rtu_rsp_ack_i       (rsp_ack),
    .rtu_dst_port_mask_o (dst_mask),
    .rtu_drop_o          (drop_o),
    .rtu_prio_o          (prio_o),
    .err_o               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0] mask;
    logic         drop;
    logic [P-1:0] prio;
  } ent_t;

  typedef struct {
    bit           rst;
    bit           vld;
    logic [W-1:0] port;
    logic [N-1:0] mask;
    bit           drop;
    logic [P-1:0] prio;
    logic [N-1:0] ack;
    bit           chk;
    bit           e_rdy;
    logic [N-1:0] e_vld;
    int           cp;
    logic [N-1:0] e_mask;
    bit           e_drop;
    logic [P-1:0] e_prio;
    bit           e_err;
  } rec_t;

  // Reference model: one queue of pending responses per port.
  ent_t m_q [N][$];
  bit   m_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(bit r, bit v, int port, int mask, bit drop, int prio, int ack,
                              bit e_rdy, int e_vld, int cp, int e_mask, bit e_drop,
                              int e_prio, bit e_err);
    rec_t x;
    x.rst = r; x.vld = v; x.port = W'(port); x.mask = N'(mask); x.drop = drop;
    x.prio = P'(prio); x.ack = N'(ack); x.chk = 1'b1; x.e_rdy = e_rdy;
    x.e_vld = N'(e_vld); x.cp = cp; x.e_mask = N'(e_mask); x.e_drop = e_drop;
    x.e_prio = P'(e_prio); x.e_err = e_err;
    return x;
  endfunction

  // One clock cycle: drive, check ready mid-cycle, advance model, check outputs.
  task automatic run_cycle(input rec_t r);
    bit           exp_rdy;
    bit           oor;
    bit           acc;
    ent_t         e;
    logic [N-1:0] ev;
    logic [N*N-1:0] em;
    logic [N-1:0] ed;
    logic [N*P-1:0] ep;
    rst       = r.rst;
    req_valid = r.vld;
    req_port  = r.port;
    req_mask  = r.mask;
    req_drop  = r.drop;
    req_prio  = r.prio;
    rsp_ack   = r.ack;
    oor = (int'(r.port) >= N);
    exp_rdy = !r.rst && (oor || m_q[oor ? 0 : int'(r.port)].size() < 2 ||
                         r.ack[oor ? 0 : int'(r.port)]);
    @(negedge clk);
    chk("ready_model", 128'(req_ready), 128'(exp_rdy));
    if (r.chk) chk("ready_table", 128'(req_ready), 128'(r.e_rdy));
    @(posedge clk);
    if (r.rst) begin
      for (int i = 0; i < N; i++) m_q[i].delete();
      m_err = 1'b0;
    end else begin
      acc = r.vld && exp_rdy;
      for (int i = 0; i < N; i++)
        if (r.ack[i] && m_q[i].size() > 0) void'(m_q[i].pop_front());
      m_err = acc && oor;
      if (acc && !oor) begin
        e.mask = r.mask;
        e.mask[r.port] = 1'b0;
        e.drop = r.drop || (e.mask == 0);
        e.prio = r.prio;
        m_q[r.port].push_back(e);
      end
    end
    #1;
    ev = '0; em = '0; ed = '0; ep = '0;
    for (int i = 0; i < N; i++) begin
      if (m_q[i].size() > 0) begin
        ev[i] = 1'b1;
        em[i*N +: N] = m_q[i][0].mask;
        ed[i] = m_q[i][0].drop;
        ep[i*P +: P] = m_q[i][0].prio;
      end
    end
    chk("valid_model", 128'(rsp_valid), 128'(ev));
    chk("mask_model",  128'(dst_mask),  128'(em));
    chk("drop_model",  128'(drop_o),    128'(ed));
    chk("prio_model",  128'(prio_o),    128'(ep));
    chk("err_model",   128'(err),       128'(m_err));
    if (r.chk) begin
      chk("valid_table", 128'(rsp_valid), 128'(r.e_vld));
      chk("mask_table",  128'(dst_mask[r.cp*N +: N]), 128'(r.e_mask));
      chk("drop_table",  128'(drop_o[r.cp]), 128'(r.e_drop));
      chk("prio_table",  128'(prio_o[r.cp*P +: P]), 128'(r.e_prio));
      chk("err_table",   128'(err), 128'(r.e_err));
    end
  endtask

  rec_t tbl [$];
  rec_t rr;

  initial begin
    m_err = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_port = '0; req_mask = '0;
    req_drop = 1'b0; req_prio = '0; rsp_ack = '0;

    //          rst v port mask   d pr ack    rdy vld    cp mask   d pr err
    // reset held three cycles
    tbl.push_back(mk(1, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 2, 'h000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 2, 'h000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 2, 'h000, 0, 0, 0));
    // basic path: port 2's own bit (bit 2) is removed from 0x00C
    tbl.push_back(mk(0, 1, 2, 'h00C, 0, 5, 'h000, 1, 'h004, 2, 'h008, 0, 5, 0));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h004, 1, 'h000, 2, 'h000, 0, 0, 0));
    // self-bit clear, then zero-mask forced drop
    tbl.push_back(mk(0, 1, 3, 'h7FF, 0, 1, 'h000, 1, 'h008, 3, 'h7F7, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h008, 1, 'h000, 3, 'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4, 'h010, 0, 2, 'h000, 1, 'h010, 4, 'h000, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h010, 1, 'h000, 4, 'h000, 0, 0, 0));
    // depth and backpressure on port 0: A, B, C(blocked), C with ack
    tbl.push_back(mk(0, 1, 0, 'h002, 0, 1, 'h000, 1, 'h001, 0, 'h002, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 'h004, 0, 2, 'h000, 1, 'h001, 0, 'h002, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 'h008, 0, 3, 'h000, 0, 'h001, 0, 'h002, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 'h008, 0, 3, 'h001, 1, 'h001, 0, 'h004, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h001, 1, 'h001, 0, 'h008, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h001, 1, 'h000, 0, 'h000, 0, 0, 0));
    // simultaneous accept and ack on port 1
    tbl.push_back(mk(0, 1, 1, 'h100, 1, 4, 'h000, 1, 'h002, 1, 'h100, 1, 4, 0));
    tbl.push_back(mk(0, 1, 1, 'h200, 0, 6, 'h002, 1, 'h002, 1, 'h200, 0, 6, 0));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h002, 1, 'h000, 1, 'h000, 0, 0, 0));
    // ports 0 and 5 acked together
    tbl.push_back(mk(0, 1, 0, 'h400, 0, 7, 'h000, 1, 'h001, 0, 'h400, 0, 7, 0));
    tbl.push_back(mk(0, 1, 5, 'h001, 0, 0, 'h000, 1, 'h021, 5, 'h001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h021, 1, 'h000, 5, 'h000, 0, 0, 0));
    // out-of-range port, then stray ack on idle port 6
    tbl.push_back(mk(0, 1, 11, 'h7FF, 0, 3, 'h000, 1, 'h000, 0, 'h000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h040, 1, 'h000, 6, 'h000, 0, 0, 0));
    // reset mid-operation: fill ports 0 and 7
    tbl.push_back(mk(0, 1, 0, 'h002, 0, 1, 'h000, 1, 'h001, 0, 'h002, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 'h004, 0, 2, 'h000, 1, 'h001, 0, 'h002, 0, 1, 0));
    tbl.push_back(mk(0, 1, 7, 'h001, 0, 3, 'h000, 1, 'h081, 7, 'h001, 0, 3, 0));
    tbl.push_back(mk(0, 1, 7, 'h002, 0, 4, 'h000, 1, 'h081, 7, 'h001, 0, 3, 0));
    tbl.push_back(mk(0, 1, 7, 'h004, 0, 5, 'h000, 0, 'h081, 7, 'h001, 0, 3, 0));
    tbl.push_back(mk(0, 1, 12, 'h004, 0, 5, 'h000, 1, 'h081, 7, 'h001, 0, 3, 1));
    tbl.push_back(mk(1, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 7, 'h000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 'h010, 0, 5, 'h000, 1, 'h080, 7, 'h010, 0, 5, 0));
    tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 'h080, 1, 'h000, 7, 'h000, 0, 0, 0));

    @(posedge clk); #1;
    for (int k = 0; k < tbl.size(); k++) run_cycle(tbl[k]);

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      rr = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rr.chk  = 1'b0;
      rr.rst  = ($urandom_range(0, 59) == 0);
      rr.vld  = ($urandom_range(0, 9) < 7);
      rr.port = W'($urandom_range(0, 15));
      rr.mask = N'($urandom);
      if ($urandom_range(0, 3) == 0) rr.mask = N'(1) << $urandom_range(0, N-1);
      rr.drop = ($urandom_range(0, 7) == 0);
      rr.prio = P'($urandom);
      for (int i = 0; i < N; i++) rr.ack[i] = ($urandom_range(0, 9) < 3);
      run_cycle(rr);
    end

    // held ack on port 9 drains one entry per cycle, with a push on the first
    run_cycle(mk(1, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 9, 'h000, 0, 0, 0));
    run_cycle(mk(0, 1, 9, 'h003, 0, 1, 'h000, 1, 'h200, 9, 'h003, 0, 1, 0));
    run_cycle(mk(0, 1, 9, 'h030, 1, 2, 'h000, 1, 'h200, 9, 'h003, 0, 1, 0));
    run_cycle(mk(0, 1, 9, 'h300, 0, 3, 'h200, 1, 'h200, 9, 'h030, 1, 2, 0));
    run_cycle(mk(0, 0, 9, 'h000, 0, 0, 'h200, 1, 'h200, 9, 'h100, 0, 3, 0));
    run_cycle(mk(0, 0, 9, 'h000, 0, 0, 'h200, 1, 'h000, 9, 'h000, 0, 0, 0));
    run_cycle(mk(0, 0, 9, 'h000, 0, 0, 'h200, 1, 'h000, 9, 'h000, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
